hex_word_scroll_ctrl: RTL

//  Sequencer for the 4-glyph word on the six-digit HEX display bank. A

---
 rtl/hex_word_scroll_ctrl_if.sv | 9 +
 rtl/hex_word_scroll_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/hex_word_scroll_ctrl_if.sv
// hex_word_scroll_ctrl_if: switch/key inputs and HEX/LEDR outputs of the scroll controller
interface hex_word_scroll_ctrl_if;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [0:6] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;
    modport master (output SW, KEY, input HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
    modport slave (input SW, KEY, output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
endinterface

// File: rtl/hex_word_scroll_ctrl.sv
// hex_word_scroll_ctrl: scrolls a 4-glyph word across six HEX digits (auto, key step or switch load)
// Optional HEX_BLINK_EN: blanks all digits in the second half of each TICK_DIV period while paused.
module hex_word_scroll_ctrl #(
    parameter int TICK_DIV = 25_000_000
) (
    input logic CLOCK_50,
    input logic RESET,
    hex_word_scroll_ctrl_if.slave io
);
    typedef enum logic [1:0] {PAUSE, RUN, MANUAL} state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [0:6] BL = 7'b1111111;
    localparam logic [0:6] GLYPH [4] = '{7'b0000001, 7'b1001111, 7'b0110000, 7'b1000010};
    state_t state, state_nxt;
    logic [5:0] sw_q;
    logic [2:0] key_s;
    logic [PW-1:0] presc, presc_nxt;
    logic [2:0] pos, pos_nxt;
    logic step, tick, change, adv, blank;
    logic [0:6] hex_q [6];
    logic [9:0] ledr_q;
    logic unused;
    assign unused = ^{io.KEY[1], io.SW[6:3]};

    // digit d shows glyph (d - p) mod 6, blank for offsets 4 and 5
    function automatic logic [0:6] glyph(input logic [2:0] d, input logic [2:0] p);
        logic [2:0] k;
        k = d >= p ? d - p : d + 3'd6 - p;
        return k < 3'd4 ? GLYPH[k[1:0]] : BL;
    endfunction

    always_comb begin
        state_nxt = sw_q[2] ? MANUAL : sw_q[0] ? RUN : PAUSE;
        change = state_nxt != state;
        tick = state == RUN && presc == PW'(TICK_DIV - 1);
        step = key_s[2] & ~key_s[1];
        presc_nxt = state == RUN && !change && !tick ? presc + 1'b1 : '0;
        adv = !change && (state == RUN ? tick : state == PAUSE && step);
        pos_nxt = !change && state == MANUAL && sw_q[5:3] <= 3'd5 ? sw_q[5:3] :
                  !adv ? pos :
                  sw_q[1] ? (pos == 3'd0 ? 3'd5 : pos - 3'd1) :
                            (pos == 3'd5 ? 3'd0 : pos + 3'd1);
    end

`ifdef HEX_BLINK_EN
    logic [PW-1:0] blink;
    always_ff @(posedge CLOCK_50 or posedge RESET)
        if (RESET) blink <= '0;
        else blink <= blink == PW'(TICK_DIV - 1) ? '0 : blink + 1'b1;
    assign blank = state == PAUSE && blink >= PW'(TICK_DIV / 2);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge RESET)
        if (RESET) begin
            state <= PAUSE;
            sw_q <= '0;
            key_s <= '1;
            presc <= '0;
            pos <= '0;
            ledr_q <= 10'h001;
            for (int d = 0; d < 6; d++) hex_q[d] <= glyph(3'(d), 3'd0);
        end else begin
            state <= state_nxt;
            sw_q <= {io.SW[9:7], io.SW[2:0]};
            key_s <= {key_s[1:0], io.KEY[0]};
            presc <= presc_nxt;
            pos <= pos_nxt;
            ledr_q <= {state == RUN, state == MANUAL, 2'b00, 6'b1 << pos};
            for (int d = 0; d < 6; d++) hex_q[d] <= blank ? BL : glyph(3'(d), pos);
        end

    assign io.HEX0 = hex_q[0];
    assign io.HEX1 = hex_q[1];
    assign io.HEX2 = hex_q[2];
    assign io.HEX3 = hex_q[3];
    assign io.HEX4 = hex_q[4];
    assign io.HEX5 = hex_q[5];
    assign io.LEDR = ledr_q;
endmodule
